// File: rtl/hue_window_scheduler.sv
// Round-robin hue-window scheduler: services one enabled colour slot per video frame,
// accumulating match count and bounding box, and publishes each frame result over valid/ready.
module hue_window_scheduler #(
    parameter int IMAGE_W   = 640,
    parameter int IMAGE_H   = 480,
    parameter int MIN_COUNT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sop,
    input  logic        in_valid,
    input  logic        packet_video,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [8:0]  hue,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic        cfg_en,
    input  logic [8:0]  cfg_lo,
    input  logic [8:0]  cfg_hi,
    output logic [8:0]  hue_lo,
    output logic [8:0]  hue_hi,
    output logic [1:0]  active_colour,
    output logic        overlay_en,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_colour,
    output logic        res_found,
    output logic [18:0] res_count,
    output logic [10:0] res_xmin,
    output logic [10:0] res_xmax,
    output logic [10:0] res_ymin,
    output logic [10:0] res_ymax,
    output logic [7:0]  res_drop_cnt
);
    // state  | meaning
    // IDLE   | no slot enabled, window outputs parked at 0
    // ARMED  | waiting for a video sop to pick the next slot
    // ACTIVE | accumulating matches for the selected slot
    // REPORT | one cycle: publish the frame result or count a drop
    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, REPORT} state_t;
    state_t state, state_nxt;

    localparam logic [18:0] COUNT_MAX = '1;
    localparam logic [10:0] COORD_MAX = '1;

    logic [3:0]  slot_en;
    logic [8:0]  slot_lo [4];
    logic [8:0]  slot_hi [4];

    logic        beat, beat_sop;
    logic [10:0] beat_x, beat_y;
    logic [8:0]  beat_hue;

    logic [1:0]  slot_q, last_q, next_slot, start_slot;
    logic [8:0]  lo_q, hi_q, win_lo, win_hi;
    logic [18:0] acc_count, base_count;
    logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [10:0] base_xmin, base_xmax, base_ymin, base_ymax;
    logic        any_en, is_last, start_sel, restart, start, accumulate, hit, report_load;

    // Pixel beats are registered once; this stage sets the two-edge result latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat     <= 1'b0;
            beat_sop <= 1'b0;
            beat_x   <= '0;
            beat_y   <= '0;
            beat_hue <= '0;
        end else begin
            beat     <= in_valid && packet_video;
            beat_sop <= sop;
            beat_x   <= x;
            beat_y   <= y;
            beat_hue <= hue;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_en <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_lo[i] <= '0;
                slot_hi[i] <= '0;
            end
        end else if (cfg_we) begin
            slot_en[cfg_addr] <= cfg_en;
            slot_lo[cfg_addr] <= cfg_lo;
            slot_hi[cfg_addr] <= cfg_hi;
        end
    end

    // Smallest offset after the last-serviced slot wins, giving round-robin order.
    always_comb begin
        next_slot = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (slot_en[2'(last_q + 2'(k))]) next_slot = 2'(last_q + 2'(k));
        end
    end

    assign any_en      = |slot_en;
    assign is_last     = (beat_x == 11'(IMAGE_W - 1)) && (beat_y == 11'(IMAGE_H - 1));
    assign start_sel   = (state == ARMED) && beat && beat_sop && any_en;
    assign restart     = (state == ACTIVE) && beat && beat_sop;
    assign start       = start_sel || restart;
    assign accumulate  = start || ((state == ACTIVE) && beat);
    assign start_slot  = start_sel ? next_slot : slot_q;
    assign win_lo      = start ? slot_lo[start_slot] : lo_q;
    assign win_hi      = start ? slot_hi[start_slot] : hi_q;
    assign hit         = (win_lo <= win_hi) ? (beat_hue >= win_lo && beat_hue <= win_hi)
                                            : (beat_hue >= win_lo || beat_hue <= win_hi);
    assign base_count  = start ? '0 : acc_count;
    assign base_xmin   = start ? COORD_MAX : acc_xmin;
    assign base_xmax   = start ? '0 : acc_xmax;
    assign base_ymin   = start ? COORD_MAX : acc_ymin;
    assign base_ymax   = start ? '0 : acc_ymax;
    assign report_load = !res_valid || res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_en) state_nxt = ARMED;
            ARMED:   if (beat && beat_sop) state_nxt = any_en ? ACTIVE : IDLE;
            ACTIVE:  if (beat && !beat_sop && is_last) state_nxt = REPORT;
            REPORT:  state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hue_lo        = '0;
        hue_hi        = '0;
        active_colour = '0;
        overlay_en    = 1'b0;
        if (state != IDLE) begin
            hue_lo        = lo_q;
            hue_hi        = hi_q;
            active_colour = slot_q;
        end
        if (state == ACTIVE) overlay_en = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= '0;
            last_q       <= 2'd3;
            lo_q         <= '0;
            hi_q         <= '0;
            acc_count    <= '0;
            acc_xmin     <= COORD_MAX;
            acc_xmax     <= '0;
            acc_ymin     <= COORD_MAX;
            acc_ymax     <= '0;
            res_valid    <= 1'b0;
            res_colour   <= '0;
            res_found    <= 1'b0;
            res_count    <= '0;
            res_xmin     <= '0;
            res_xmax     <= '0;
            res_ymin     <= '0;
            res_ymax     <= '0;
            res_drop_cnt <= '0;
        end else begin
            if (start) begin
                slot_q <= start_slot;
                lo_q   <= slot_lo[start_slot];
                hi_q   <= slot_hi[start_slot];
            end
            if (accumulate) begin
                acc_count <= (hit && base_count != COUNT_MAX) ? base_count + 19'd1 : base_count;
                acc_xmin  <= (hit && beat_x < base_xmin) ? beat_x : base_xmin;
                acc_xmax  <= (hit && beat_x > base_xmax) ? beat_x : base_xmax;
                acc_ymin  <= (hit && beat_y < base_ymin) ? beat_y : base_ymin;
                acc_ymax  <= (hit && beat_y > base_ymax) ? beat_y : base_ymax;
            end
            if (state == REPORT) begin
                last_q <= slot_q;
                if (report_load) begin
                    res_valid  <= 1'b1;
                    res_colour <= slot_q;
                    res_found  <= (acc_count >= 19'(MIN_COUNT));
                    res_count  <= acc_count;
                    res_xmin   <= acc_xmin;
                    res_xmax   <= acc_xmax;
                    res_ymin   <= acc_ymin;
                    res_ymax   <= acc_ymax;
                end else if (res_drop_cnt != 8'hFF) begin
                    res_drop_cnt <= res_drop_cnt + 8'd1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hue_window_scheduler.sv
// Self-checking bench for hue_window_scheduler: directed frames with literal expectations,
// then randomized traffic compared every cycle against a frame-level reference model.
module tb_hue_window_scheduler;
    localparam int W = 4;
    localparam int H = 4;
    localparam int MINC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sop = 1'b0, in_valid = 1'b0, packet_video = 1'b0;
    logic [10:0] x = '0, y = '0;
    logic [8:0]  hue = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic        cfg_en = 1'b0;
    logic [8:0]  cfg_lo = '0, cfg_hi = '0;
    logic        res_ready = 1'b0;
    logic [8:0]  hue_lo, hue_hi;
    logic [1:0]  active_colour, res_colour;
    logic        overlay_en, res_valid, res_found;
    logic [18:0] res_count;
    logic [10:0] res_xmin, res_xmax, res_ymin, res_ymax;
    logic [7:0]  res_drop_cnt;

    int n_checks = 0;
    int n_pass = 0;
    bit rand_ready = 1'b0;

    hue_window_scheduler #(.IMAGE_W(W), .IMAGE_H(H), .MIN_COUNT(MINC)) dut (
        .clk(clk), .reset(reset), .sop(sop), .in_valid(in_valid), .packet_video(packet_video),
        .x(x), .y(y), .hue(hue), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .hue_lo(hue_lo), .hue_hi(hue_hi),
        .active_colour(active_colour), .overlay_en(overlay_en), .res_valid(res_valid),
        .res_ready(res_ready), .res_colour(res_colour), .res_found(res_found),
        .res_count(res_count), .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin),
        .res_ymax(res_ymax), .res_drop_cnt(res_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: config table, frame bookkeeping and result slot, advanced once per edge.
    bit [3:0] m_en;
    int m_lo [4];
    int m_hi [4];
    int phase;
    int m_slot, m_blo, m_bhi, m_last;
    int m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
    bit m_rv, m_rfound;
    int m_rc, m_rcnt, m_rxmin, m_rxmax, m_rymin, m_rymax, m_drop;
    bit p_v, p_sop;
    int p_x, p_y, p_hue;

    function automatic bit in_window(input int lo, input int hi, input int h);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    function automatic void m_begin(input int s);
        m_slot = s;
        m_blo  = m_lo[s];
        m_bhi  = m_hi[s];
        m_cnt  = 0;
        m_xmin = 2047; m_ymin = 2047;
        m_xmax = 0;    m_ymax = 0;
    endfunction

    function automatic void m_take(input int h, input int bx, input int by);
        if (in_window(m_blo, m_bhi, h)) begin
            if (m_cnt < 524287) m_cnt++;
            if (bx < m_xmin) m_xmin = bx;
            if (bx > m_xmax) m_xmax = bx;
            if (by < m_ymin) m_ymin = by;
            if (by > m_ymax) m_ymax = by;
        end
    endfunction

    function automatic void m_reset();
        m_en = '0;
        for (int i = 0; i < 4; i++) begin m_lo[i] = 0; m_hi[i] = 0; end
        phase = 0; m_slot = 0; m_blo = 0; m_bhi = 0; m_last = 3;
        m_cnt = 0; m_xmin = 2047; m_ymin = 2047; m_xmax = 0; m_ymax = 0;
        m_rv = 0; m_rfound = 0; m_rc = 0; m_rcnt = 0;
        m_rxmin = 0; m_rxmax = 0; m_rymin = 0; m_rymax = 0; m_drop = 0;
        p_v = 0; p_sop = 0; p_x = 0; p_y = 0; p_hue = 0;
    endfunction

    function automatic void m_step();
        bit any;
        bit was_report;
        int s;
        any = (m_en != 4'b0);
        was_report = (phase == 3);
        case (phase)
            0: if (any) phase = 1;
            1: if (p_v && p_sop) begin
                if (any) begin
                    s = m_last;
                    for (int k = 4; k >= 1; k--) if (m_en[(m_last + k) % 4]) s = (m_last + k) % 4;
                    m_begin(s);
                    m_take(p_hue, p_x, p_y);
                    phase = 2;
                end else phase = 0;
            end
            2: if (p_v) begin
                if (p_sop) begin
                    m_begin(m_slot);
                    m_take(p_hue, p_x, p_y);
                end else begin
                    m_take(p_hue, p_x, p_y);
                    if (p_x == W - 1 && p_y == H - 1) phase = 3;
                end
            end
            default: begin
                if (!m_rv || res_ready) begin
                    m_rv = 1; m_rc = m_slot; m_rcnt = m_cnt; m_rfound = (m_cnt >= MINC);
                    m_rxmin = m_xmin; m_rxmax = m_xmax; m_rymin = m_ymin; m_rymax = m_ymax;
                end else if (m_drop < 255) m_drop++;
                m_last = m_slot;
                phase = 1;
            end
        endcase
        if (!was_report && m_rv && res_ready) m_rv = 0;
        if (cfg_we) begin
            m_en[cfg_addr] = cfg_en;
            m_lo[cfg_addr] = int'(cfg_lo);
            m_hi[cfg_addr] = int'(cfg_hi);
        end
        p_v = in_valid && packet_video; p_sop = sop;
        p_x = int'(x); p_y = int'(y); p_hue = int'(hue);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else m_step();
    end

    function automatic logic [95:0] dut_vec();
        return {hue_lo, hue_hi, active_colour, overlay_en, res_valid, res_colour, res_found,
                res_count, res_xmin, res_xmax, res_ymin, res_ymax, res_drop_cnt};
    endfunction

    function automatic logic [95:0] exp_vec();
        bit on;
        on = (phase != 0);
        return {on ? 9'(m_blo) : 9'd0, on ? 9'(m_bhi) : 9'd0, on ? 2'(m_slot) : 2'd0,
                phase == 2, m_rv, 2'(m_rc), m_rfound, 19'(m_rcnt),
                11'(m_rxmin), 11'(m_rxmax), 11'(m_rymin), 11'(m_rymax), 8'(m_drop)};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (dut_vec() === exp_vec()) n_pass++;
            else $display("FAIL model_compare t=%0t got=%h expected=%h", $time, dut_vec(), exp_vec());
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic drive(input bit s, input bit v, input bit vid, input int bx, input int by, input int bh);
        sop = s; in_valid = v; packet_video = vid;
        x = 11'(bx); y = 11'(by); hue = 9'(bh);
        if (rand_ready) res_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg_write(input int a, input bit e, input int lo, input int hi);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_en = e; cfg_lo = 9'(lo); cfg_hi = 9'(hi);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        cfg_we = 1'b0;
    endtask

    task automatic frame(input int hv [16]);
        for (int i = 0; i < 16; i++) drive(i == 0, 1'b1, 1'b1, i % W, i / W, hv[i]);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            idle(1);
            lat++;
        end
        if (lat >= 20) chk("res_valid_timeout", 96'(res_valid), 96'(1));
    endtask

    task automatic do_reset();
        sop = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        #2 reset = 1'b1;
        #1 chk("reset_outputs_zero", dut_vec(), '0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_frame();
        int i;
        int r;
        i = 0;
        while (i < 16) begin
            r = int'($urandom_range(0, 31));
            if (r < 4) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
            else if (r < 6) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 3, 3, int'($urandom_range(0, 359)));
            else if (r == 6 && i > 2) begin
                drive(1'b1, 1'b1, 1'b1, i % W, i / W, int'($urandom_range(0, 359)));
                i++;
            end else if (r == 7) begin
                cfg_write(int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 359)), int'($urandom_range(0, 359)));
            end else begin
                drive(i == 0, 1'b1, 1'b1, i % W, i / W, int'($urandom_range(0, 359)));
                i++;
            end
        end
        idle(int'($urandom_range(2, 5)));
    endtask

    initial begin
        int hv [16];
        int lat;
        int exp_c [4];
        @(negedge clk);
        chk("init_outputs_zero", dut_vec(), '0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Slot 0 window 100..155, two matching pixels.
        res_ready = 1'b1;
        cfg_write(0, 1'b1, 100, 155);
        idle(1);
        hv = '{default: 0};
        hv[5] = 120; hv[14] = 120;
        frame(hv);
        wait_valid(lat);
        chk("latency_edges", 96'(lat), 96'(2));
        chk("basic_colour", 96'(res_colour), 96'(0));
        chk("basic_count", 96'(res_count), 96'(2));
        chk("basic_found", 96'(res_found), 96'(1));
        chk("basic_bbox", {res_xmin, res_xmax, res_ymin, res_ymax}, {11'd1, 11'd2, 11'd1, 11'd3});
        idle(2);

        // Wrapping window on slot 1.
        cfg_write(0, 1'b0, 0, 0);
        cfg_write(1, 1'b1, 350, 10);
        idle(1);
        hv = '{default: 200};
        hv[0] = 355; hv[1] = 5; hv[2] = 10; hv[3] = 11; hv[4] = 349;
        frame(hv);
        wait_valid(lat);
        chk("wrap_colour", 96'(res_colour), 96'(1));
        chk("wrap_count", 96'(res_count), 96'(3));
        chk("wrap_bbox", {res_xmin, res_xmax, res_ymin, res_ymax}, {11'd0, 11'd2, 11'd0, 11'd0});
        idle(2);

        // Round-robin between slots 0 and 2.
        do_reset();
        res_ready = 1'b1;
        cfg_write(0, 1'b1, 0, 359);
        cfg_write(2, 1'b1, 0, 359);
        idle(1);
        hv = '{default: 0};
        exp_c = '{0, 2, 0, 2};
        for (int f = 0; f < 4; f++) begin
            frame(hv);
            wait_valid(lat);
            chk($sformatf("rr_colour_%0d", f), 96'(res_colour), 96'(exp_c[f]));
        end
        idle(2);

        // Back-pressure: first result held, second dropped.
        do_reset();
        res_ready = 1'b0;
        cfg_write(0, 1'b1, 100, 155);
        idle(1);
        hv = '{default: 0};
        hv[5] = 120; hv[14] = 120;
        frame(hv);
        wait_valid(lat);
        hv = '{default: 120};
        frame(hv);
        idle(4);
        chk("hold_valid", 96'(res_valid), 96'(1));
        chk("hold_count", 96'(res_count), 96'(2));
        chk("hold_xmin", 96'(res_xmin), 96'(1));
        chk("drop_cnt", 96'(res_drop_cnt), 96'(1));
        res_ready = 1'b1;
        idle(1);
        chk("release_valid", 96'(res_valid), 96'(0));

        // Mid-frame sop at (2,1) restarts the same slot.
        do_reset();
        res_ready = 1'b1;
        cfg_write(0, 1'b1, 0, 359);
        cfg_write(2, 1'b1, 0, 359);
        idle(1);
        for (int i = 0; i < 16; i++) drive(i == 0 || i == 6, 1'b1, 1'b1, i % W, i / W, 0);
        wait_valid(lat);
        chk("abort_colour", 96'(res_colour), 96'(0));
        chk("abort_count", 96'(res_count), 96'(10));
        chk("abort_bbox", {res_xmin, res_xmax, res_ymin, res_ymax}, {11'd0, 11'd3, 11'd1, 11'd3});
        idle(2);

        // Reset mid-frame clears the config table as well.
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, 1'b1, i % W, i / W, 0);
        do_reset();
        hv = '{default: 0};
        frame(hv);
        idle(4);
        chk("post_reset_no_result", 96'(res_valid), 96'(0));
        chk("post_reset_idle", {hue_lo, hue_hi, active_colour, overlay_en}, '0);
        cfg_write(1, 1'b1, 0, 359);
        idle(1);
        frame(hv);
        wait_valid(lat);
        chk("post_reset_slot", 96'(res_colour), 96'(1));
        idle(2);

        // Randomized traffic, checked cycle by cycle against the model.
        do_reset();
        rand_ready = 1'b1;
        cfg_write(int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 359)), int'($urandom_range(0, 359)));
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write(int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 359)), int'($urandom_range(0, 359)));
            rand_frame();
        end
        rand_ready = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
